// File: rtl/seg_scan_drv_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package seg_scan_drv_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } scan_state_e;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_ALL_OFF_N = 7'h7F;

endpackage

// File: rtl/seg_scan_drv_if.sv
// Frame handshake between the producer (ALU result path) and the scan driver.
interface seg_scan_drv_if #(parameter int DIGITS = 8);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;
    logic [DIGITS-1:0]     in_dp;
    logic [DIGITS-1:0]     in_blank;

    modport master (output in_valid, output in_data, output in_dp, output in_blank, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dp, input in_blank, output in_ready);

endinterface

// File: rtl/seg_scan_drv_hex_dec.sv
// Combinational hex nibble to active-high seven-segment decoder.
module seg_hex_dec
    import seg_scan_drv_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg_o = HEX_SEG[nib_i];
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed hex display driver: one-entry frame buffer, OFF/ON/GAP scan FSM,
// registered active-low segment, decimal-point and anode outputs.
module seg_scan_drv
    import seg_scan_drv_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000,
    parameter int GAP      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_drv_if.slave      in_if,
    output logic [6:0]         seg_n,
    output logic               dp_n,
    output logic [DIGITS-1:0]  an_n
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]  pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]    pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic                 in_ready_q, in_ready_d;
    logic [6:0]           seg_n_q, seg_n_d;
    logic                 dp_n_q, dp_n_d;
    logic [DIGITS-1:0]    an_n_q, an_n_d;
    logic                 xfer_s;
    logic [3:0]           nib_s;
    logic [6:0]           hex_seg_s;

    assign xfer_s         = in_if.in_valid && in_ready_q;
    assign in_if.in_ready = in_ready_q;
    assign seg_n          = seg_n_q;
    assign dp_n           = dp_n_q;
    assign an_n           = an_n_q;

    seg_hex_dec u_hex_dec (
        .nib_i (nib_s),
        .seg_o (hex_seg_s)
    );

    // Next-state: frame capture, scan timing and frame-boundary copy.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;

        // A transfer only happens with pending empty, a copy only with it full.
        if (xfer_s) begin
            pend_valid_d = 1'b1;
            pend_data_d  = in_if.in_data;
            pend_dp_d    = in_if.in_dp;
            pend_blank_d = in_if.in_blank;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            ST_OFF: begin
                if (pend_valid_q) begin
                    disp_data_d  = pend_data_q;
                    disp_dp_d    = pend_dp_q;
                    disp_blank_d = pend_blank_q;
                    pend_valid_d = 1'b0;
                    idx_d        = '0;
                    cnt_d        = '0;
                    state_d      = ST_ON;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_ON: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ON;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d = '0;
                        if (pend_valid_q) begin
                            disp_data_d  = pend_data_q;
                            disp_dp_d    = pend_dp_q;
                            disp_blank_d = pend_blank_q;
                            pend_valid_d = 1'b0;
                        end else begin
                            pend_valid_d = pend_valid_q;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs decoded from next state so the register tracks the FSM cycle-exactly.
    always_comb begin
        in_ready_d = ~pend_valid_d;
        an_n_d     = '1;
        seg_n_d    = SEG_ALL_OFF_N;
        dp_n_d     = 1'b1;
        nib_s      = disp_data_d[{idx_d, 2'b00} +: 4];
        if (state_d == ST_ON) begin
            an_n_d[idx_d] = 1'b0;
            if (disp_blank_d[idx_d]) begin
                seg_n_d = SEG_ALL_OFF_N;
                dp_n_d  = 1'b1;
            end else begin
                seg_n_d = ~hex_seg_s;
                dp_n_d  = ~disp_dp_d[idx_d];
            end
        end else begin
            an_n_d = '1;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            in_ready_q   <= 1'b0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_ALL_OFF_N;
            dp_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            in_ready_q   <= in_ready_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv (DIGITS=4, SCAN_DIV=3, GAP=1) against a
// time-position reference model of the display scan.
module tb_seg_scan_drv;

    localparam int DIGITS = 4;
    localparam int S      = 3;
    localparam int G      = 1;
    localparam int PER    = S + G;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } exp_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;

    seg_scan_drv_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_drv #(.DIGITS(DIGITS), .SCAN_DIV(S), .GAP(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_if (bus),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    logic [6:0] tb_seg [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    exp_t   q[$];
    int     vectors    = 0;
    int     miscompares = 0;

    // Reference model state: whether a scan is running and its position in time.
    logic   m_run, m_pend_v, m_ready;
    int     m_t;
    frame_t m_pend, m_disp;

    function automatic exp_t reset_exp();
        exp_t e;
        e.rdy = 1'b0; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        return e;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int slot, ph;
        logic [15:0] sh;
        logic [3:0]  nib;
        e.rdy = m_ready; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (m_run) begin
            slot = m_t / PER;
            ph   = m_t % PER;
            if (ph < S) begin
                e.an[slot] = 1'b0;
                if (!m_disp.bl[slot]) begin
                    sh    = m_disp.d >> (4 * slot);
                    nib   = sh[3:0];
                    e.seg = ~tb_seg[nib];
                    e.dp  = ~m_disp.dp[slot];
                end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pend_v = 1'b0; m_ready = 1'b0; m_t = 0;
        m_pend = '0; m_disp = '0;
    endtask

    // Model advance on each clock edge; pushes the expected output for the next cycle.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                q.push_back(reset_exp());
            end else begin
                logic xfer;
                xfer = bus.in_valid && m_ready;
                if (!m_run) begin
                    if (m_pend_v) begin
                        m_disp = m_pend; m_pend_v = 1'b0; m_run = 1'b1; m_t = 0;
                    end
                end else begin
                    m_t = m_t + 1;
                    if (m_t == DIGITS * PER) begin
                        m_t = 0;
                        if (m_pend_v) begin
                            m_disp = m_pend; m_pend_v = 1'b0;
                        end
                    end
                end
                if (xfer) begin
                    m_pend   = '{bus.in_data, bus.in_dp, bus.in_blank};
                    m_pend_v = 1'b1;
                end
                m_ready = !m_pend_v;
                q.push_back(model_out());
            end
        end
    end

    // Asynchronous reset replaces the current cycle's expectation immediately.
    initial begin
        forever begin
            @(negedge rst_n);
            model_reset();
            if (q.size() > 0) begin
                void'(q.pop_back());
                q.push_back(reset_exp());
            end
        end
    end

    // Monitor: compare DUT outputs every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL underflow: no expectation queued at %0t", $time);
            end else begin
                exp_t e, a;
                e = q.pop_front();
                a = '{bus.in_ready, an_n, seg_n, dp_n};
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got rdy=%b an_n=%h seg_n=%h dp_n=%b, want rdy=%b an_n=%h seg_n=%h dp_n=%b",
                             $time, a.rdy, a.an, a.seg, a.dp, e.rdy, e.an, e.seg, e.dp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_dp = dp; bus.in_blank = bl;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dp = '0; bus.in_blank = '0;
        idle(3);
        rst_n = 1'b1;
        idle(12);

        send(16'h1A30, 4'b0010, 4'b0000);
        idle(40);

        send(16'h1111, 4'b0000, 4'b0000);
        idle(6);
        send(16'h2222, 4'b0101, 4'b0000);
        send(16'h3333, 4'b1000, 4'b0000);
        idle(40);

        send(16'h0005, 4'b0000, 4'b1000);
        idle(36);

        // Load pending, then reset during digit 2's lit window.
        send(16'hBEEF, 4'b1111, 4'b0000);
        n = 0;
        while (an_n !== 4'b1011 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (an_n !== 4'b1011) begin
            miscompares++;
            $display("FAIL digit2_wait: an_n=%h, want b", an_n);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(20);

        for (int k = 0; k < 15; k++) begin
            logic [3:0] bl;
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            send(16'($urandom), 4'($urandom_range(0, 15)), bl);
            idle($urandom_range(0, 30));
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed hex digits (2..8).
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each digit is lit (>=2).
REQ-003 Parameter GAP, default 4, all-off dead cycles between digits (>=1).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  producer (ALU result path) offers a display frame.
REQ-007 in_ready  out  1  block can accept a frame this cycle.
REQ-008 in_data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i.
REQ-009 in_dp  in  DIGITS  decimal-point enable per digit.
REQ-010 in_blank  in  DIGITS  digit blank mask; 1 = digit dark.
REQ-011 seg_n  out  7  segments a..g on bits 0..6, active-low.
REQ-012 dp_n  out  1  decimal point, active-low.
REQ-013 an_n  out  DIGITS  digit enables, active-low, at most one low.

Function
REQ-014 Handshake: transfer occurs on a rising edge with in_valid && in_ready; the frame (data, dp, blank) is captured into a one-entry pending buffer.
REQ-015 in_ready is high exactly when the pending buffer is empty; in_ready does not depend combinationally on in_valid.
REQ-016 in_valid and payload are held by the producer until transfer; the block samples only on transfer.
REQ-017 States: OFF, ON, GAP.
REQ-018 OFF: an_n all high, seg_n/dp_n all high; when pending is valid, copy it to the display register, clear pending, digit index = 0, go to ON.
REQ-019 ON: an_n[idx] low for exactly SCAN_DIV cycles, then go to GAP.
REQ-020 GAP: an_n all high for exactly GAP cycles; on exit idx increments, then go to ON.
REQ-021 Wrap: on GAP exit with idx = DIGITS-1, idx becomes 0 and, if pending is valid, the display register is replaced by pending and pending clears in the same edge; frames never change mid-scan.
REQ-022 Simultaneous frame-boundary copy and new transfer: the copy wins; in_ready is low that cycle (pending was full), so no conflict arises.
REQ-023 Transfer while pending empty during a scan: frame waits in pending until the next wrap.
REQ-024 Segment decode: standard hex 0-F (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71 active-high abcdefg), inverted onto seg_n.
REQ-025 Blanked digit: an_n[idx] still low (timing unchanged), seg_n = 7F, dp_n = 1.
REQ-026 dp_n = ~in_dp[idx] of the displayed frame while in ON, 1 otherwise.
REQ-027 Latency: frame accepted on edge t from OFF is lit (digit 0) from the cycle after edge t+1.
REQ-028 All outputs registered; no glitches on an_n.

Reset
REQ-029 rst_n low: state OFF, idx 0, counters 0, pending empty, display register 0, an_n all 1, seg_n 7F, dp_n 1, in_ready 0.
REQ-030 in_ready rises the first edge after rst_n deasserts; reset mid-scan discards pending and displayed frames immediately.

Structure
REQ-031 Shared package holds the state enum and the 16-entry hex-to-segment constant table.
REQ-032 One sub-module seg_hex_dec (4-bit in, 7-bit active-high segments, combinational); counters and FSM stay in seg_scan_drv.

Verification (DIGITS=4, SCAN_DIV=3, GAP=1)
REQ-033 Reset release, no valid -> an_n=F, seg_n=7F indefinitely, in_ready=1 after one edge.
REQ-034 Send data=16'h1A30, dp=0010, blank=0 -> digit0 seg_n=40 for 3 cycles, 1 gap cycle, digit1 seg_n=30 dp_n=0, digit2 seg_n=08, digit3 seg_n=79; 16-cycle period.
REQ-035 Send frame 16'h1111, then 16'h2222 mid-scan -> second frame appears only at digit0 after wrap; third valid stalls (in_ready=0) until that wrap.
REQ-036 blank=1000 with data 16'h0005 -> digit3 an_n low, seg_n=7F; others show 5,0,0.
REQ-037 Assert rst_n low during digit2 ON -> outputs reset values same cycle, pending cleared.
